ram2e_sdram_sched: RTL and testbench
====================================

# ram2e_sdram_sched

SDRAM command scheduler for the RAM2E auxiliary-memory card. It runs the SDRAM power-up sequence, then locks to the Apple IIe PHI1 cycle. Each 14-cycle C14M window is divided into fixed slots: a video read slot, a periodic auto-refresh slot, and a CPU read/write slot addressed by the RAMWorks bank register. The block drives the SDRAM command/address pins and gives the data-capture logic one-cycle strobes telling it when read data is valid.

## Interface
- INIT_WAIT, default 16'hFF00: C14M cycles with CKE low after reset.
- REF_PERIOD, default 8: one auto-refresh per REF_PERIOD PHI cycles. Legal range 1..8.
- C14M  in  1  14.318 MHz system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- PHI1  in  1  Apple IIe PHI1, asynchronous to this block's state.
- Ain  in  8  multiplexed DRAM address from the IIe.
- nWE80  in  1  CPU write strobe for 80-column/aux memory, active low.
- EN80  in  1  aux memory enable, active high.
- Bank  in  8  RAMWorks bank register.
- S  out  4  slot counter: 0 = not running, 1..15 = running.
- Ready  out  1  high once initialization is complete.
- CKE, nCS, nRAS, nCAS, nRWE  out  1 each  SDRAM control pins.
- BA  out  2  SDRAM bank address.
- RA  out  12  SDRAM row/column address.
- DQML, DQMH  out  1 each  SDRAM byte masks.
- VidStrb  out  1  video read data valid this cycle.
- CpuStrb  out  1  CPU read data valid this cycle.
- Resync  out  1  one-cycle pulse when a PHI1 edge arrives early.

## Operation
- NOP means nCS=nRAS=nCAS=nRWE=1.
- Reset values:
  - CKE=0, NOP on the command pins, BA=0, RA=0, DQML=DQMH=1.
  - S=0, Ready=0, all strobes 0.
  - Internal 16-bit init counter FC=0, refresh counter RC=0.
- Reset asserted at any time, including mid-run, returns the block to INIT with these values.
- INIT (S=0): FC increments every cycle.
  - CKE=1 once FC ≥ INIT_WAIT.
  - At FC=INIT_WAIT+16: PRECHARGE ALL (nCS=nRAS=nRWE=0, RA[10]=1).
  - At FC=INIT_WAIT+32+2k, k=0..7: AUTO-REFRESH (nCS=nRAS=nCAS=0).
  - At FC=INIT_WAIT+56: MODE REGISTER SET (all four command pins 0), BA=0, RA=12'h220. This selects single write, CAS latency 2, sequential burst, burst length 1.
  - At FC=INIT_WAIT+64+2k, k=0..7: AUTO-REFRESH.
  - At FC=INIT_WAIT+96: Ready=1 and FC stops.
  - All other INIT cycles: NOP, DQML=DQMH=1.
- RUN: PHI1 is registered (PHI1q). An edge is PHI1 & ~PHI1q.
  - An edge with Ready=1 sets S=1 on the next cycle.
  - Otherwise, S=0 holds and S=1..14 increments. S=15 saturates until the next edge.
- Slot actions. Any slot not listed below issues NOP with DQML=DQMH=1.
  - Row address latch: RA[7:0] ← Ain at S=14, S=15 and S=7.
  - S=2: ACTIVATE, BA=0, RA[11:8]=0.
  - S=3: READ with auto-precharge. RA[10]=1, RA[11,9,8]=0, RA[7:0] ← Ain, DQML=0, DQMH=1.
  - S=6, RC=0: AUTO-REFRESH.
  - S=6, always: VidStrb=1.
  - S=7: CpuEn ← EN80, sampled.
  - S=8, CpuEn=1: ACTIVATE, BA=Bank[5:4], RA[11:8]=Bank[3:0].
  - S=9, CpuEn=1: READ or WRITE with auto-precharge; nRWE=nWE80 is sampled here.
    - RA[10]=1, RA[8]=Bank[7], RA[7:0] ← Ain.
    - DQML=Bank[6], DQMH=~Bank[6].
  - S=12: CpuStrb=1 if CpuEn=1 and nWE80 was 1 at S=9.
- Refresh counter: RC increments on every entry to S=1 and wraps to 0 after REF_PERIOD-1.
- CKE is 1 for S=1..10 and 0 for S=11..15 (clock suspend while idle).

## Timing
- Video read: READ issued at S=3, CAS latency 2, data valid while S=6. VidStrb is high for exactly that cycle.
- CPU read: READ issued at S=9, data valid while S=12. CpuStrb is high for exactly that cycle.
- Early edge (PHI1 edge while S=1..13):
  - S forces to 1 and Resync pulses for one cycle.
  - Any pending CPU command is dropped and the command pins return to NOP.
  - An already-issued auto-precharge command is allowed to complete; no extra action is taken.
- PHI1 edge during INIT (Ready=0): ignored.
- Refresh rate at REF_PERIOD=8: one refresh per 8 µs, which meets 4096 rows in 64 ms with margin.

## Test plan
- Reset, INIT_WAIT=16 → CKE rises at FC=16; PRECHARGE at FC=32; 8 refreshes at FC=48..62; MRS at FC=72 with RA=12'h220; 8 refreshes at FC=80..94; Ready=1 at FC=112.
- Ready=1, PHI1 toggling with a 14-cycle period → S runs 1..14 repeatedly; ACTIVATE at S=2; READ at S=3; VidStrb at S=6; AUTO-REFRESH only at S=6 of every 8th PHI cycle.
- EN80=1, nWE80=0, Bank=8'hC5, Ain=8'h3C at S=9 → at S=8: BA=0, RA[11:8]=5. At S=9: WRITE, BA=0, RA=12'h53C, DQML=1, DQMH=0. CpuStrb stays 0.
- EN80=0 during a CPU slot → NOP at S=8/9 and CpuStrb=0. EN80=1 with nWE80=1 → READ at S=9 and CpuStrb=1 at S=12.
- PHI1 edge at S=5 → S=1 on the next cycle, Resync=1 for one cycle, no ACT/READ/WRITE issued at S=8/9 of the aborted window.
- RST asserted at S=9 → CKE=0, NOP, S=0, Ready=0 immediately; the full INIT sequence repeats after release.

Source files
------------

// File: rtl/ram2e_sdram_sched.sv
// SDRAM command scheduler for the RAM2E aux-memory card: power-up init
// sequence, then a PHI1-locked slot schedule of video read, periodic
// auto-refresh and a RAMWorks-banked CPU read/write per 14-cycle window.
// All SDRAM pins and strobes are registered; each register is loaded from
// the next slot/init-count value so the pins line up with the S output.
module ram2e_sdram_sched #(
  parameter logic [15:0] INIT_WAIT  = 16'hFF00,
  parameter int unsigned REF_PERIOD = 8
) (
  input  logic        C14M,
  input  logic        RST,
  input  logic        PHI1,
  input  logic [7:0]  Ain,
  input  logic        nWE80,
  input  logic        EN80,
  input  logic [7:0]  Bank,
  output logic [3:0]  S,
  output logic        Ready,
  output logic        CKE,
  output logic        nCS,
  output logic        nRAS,
  output logic        nCAS,
  output logic        nRWE,
  output logic [1:0]  BA,
  output logic [11:0] RA,
  output logic        DQML,
  output logic        DQMH,
  output logic        VidStrb,
  output logic        CpuStrb,
  output logic        Resync
);

  // {nCS, nRAS, nCAS, nRWE}
  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [15:0] FC_DONE = INIT_WAIT + 16'd96;
  localparam logic [2:0]  RC_LAST = 3'(REF_PERIOD - 1);

  logic [15:0] FC_q, FC_d, off;
  logic [2:0]  RC_q, RC_d;
  logic [3:0]  S_q, S_d;
  logic        Ready_q, Ready_d;
  logic        PHI1_q;
  logic        CpuEn_q, CpuEn_d;
  logic        CpuRd_q, CpuRd_d;
  logic        CKE_q, CKE_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  BA_q, BA_d;
  logic [11:0] RA_q, RA_d;
  logic        DQML_q, DQML_d, DQMH_q, DQMH_d;
  logic        Vid_q, Vid_d, Cpu_q, Cpu_d, Resync_q, Resync_d;
  logic        phi_edge;

  assign phi_edge = PHI1 & ~PHI1_q;

  // Next-state: init counter, slot counter, refresh counter and pin values
  always_comb begin
    FC_d     = FC_q;
    RC_d     = RC_q;
    S_d      = S_q;
    Ready_d  = Ready_q;
    CpuEn_d  = CpuEn_q;
    CpuRd_d  = CpuRd_q;
    CKE_d    = 1'b0;
    cmd_d    = CMD_NOP;
    BA_d     = BA_q;
    RA_d     = RA_q;
    DQML_d   = 1'b1;
    DQMH_d   = 1'b1;
    Vid_d    = 1'b0;
    Cpu_d    = 1'b0;
    Resync_d = 1'b0;
    off      = '0;

    if (!Ready_q && FC_q != FC_DONE) FC_d = FC_q + 16'd1;
    Ready_d = Ready_q | (FC_d == FC_DONE);

    if (phi_edge && Ready_q) begin
      S_d      = 4'd1;
      Resync_d = (S_q != 4'd0) && (S_q <= 4'd13);
    end else if (S_q != 4'd0 && S_q != 4'd15) begin
      S_d = S_q + 4'd1;
    end

    if (S_d == 4'd0) begin
      CKE_d = (FC_d >= INIT_WAIT);
      if (FC_d >= INIT_WAIT) begin
        off = FC_d - INIT_WAIT;
        if (off == 16'd16) begin
          cmd_d     = CMD_PRE;
          RA_d[10]  = 1'b1;
        end else if (((off >= 16'd32 && off <= 16'd46) ||
                      (off >= 16'd64 && off <= 16'd78)) && !off[0]) begin
          cmd_d = CMD_REF;
        end else if (off == 16'd56) begin
          cmd_d = CMD_MRS;
          BA_d  = '0;
          RA_d  = 12'h220;
        end
      end
    end else begin
      CKE_d = (S_d <= 4'd10);
      case (S_d)
        4'd1: begin
          // Entering a window (normal or early) drops any pending CPU access
          CpuEn_d = 1'b0;
          RC_d    = (RC_q == RC_LAST) ? '0 : RC_q + 3'd1;
        end
        4'd2: begin
          cmd_d      = CMD_ACT;
          BA_d       = '0;
          RA_d[11:8] = '0;
        end
        4'd3: begin
          cmd_d  = CMD_RD;
          RA_d   = {4'b0100, Ain};
          DQML_d = 1'b0;
          DQMH_d = 1'b1;
        end
        4'd6: begin
          Vid_d = 1'b1;
          if (RC_q == '0) cmd_d = CMD_REF;
        end
        4'd7: begin
          RA_d[7:0] = Ain;
          CpuEn_d   = EN80;
        end
        4'd8: begin
          if (CpuEn_q) begin
            cmd_d      = CMD_ACT;
            BA_d       = Bank[5:4];
            RA_d[11:8] = Bank[3:0];
          end
        end
        4'd9: begin
          if (CpuEn_q) begin
            cmd_d   = {3'b010, nWE80};
            RA_d    = {2'b01, 1'b0, Bank[7], Ain};
            DQML_d  = Bank[6];
            DQMH_d  = ~Bank[6];
            CpuRd_d = nWE80;
          end
        end
        4'd12:        Cpu_d = CpuEn_q & CpuRd_q;
        4'd14, 4'd15: RA_d[7:0] = Ain;
        default: ;
      endcase
    end
  end

  // State and pin registers; reset returns to INIT with pins idle
  always_ff @(posedge C14M or posedge RST) begin
    if (RST) begin
      FC_q     <= '0;
      RC_q     <= '0;
      S_q      <= '0;
      Ready_q  <= 1'b0;
      PHI1_q   <= 1'b0;
      CpuEn_q  <= 1'b0;
      CpuRd_q  <= 1'b0;
      CKE_q    <= 1'b0;
      cmd_q    <= CMD_NOP;
      BA_q     <= '0;
      RA_q     <= '0;
      DQML_q   <= 1'b1;
      DQMH_q   <= 1'b1;
      Vid_q    <= 1'b0;
      Cpu_q    <= 1'b0;
      Resync_q <= 1'b0;
    end else begin
      FC_q     <= FC_d;
      RC_q     <= RC_d;
      S_q      <= S_d;
      Ready_q  <= Ready_d;
      PHI1_q   <= PHI1;
      CpuEn_q  <= CpuEn_d;
      CpuRd_q  <= CpuRd_d;
      CKE_q    <= CKE_d;
      cmd_q    <= cmd_d;
      BA_q     <= BA_d;
      RA_q     <= RA_d;
      DQML_q   <= DQML_d;
      DQMH_q   <= DQMH_d;
      Vid_q    <= Vid_d;
      Cpu_q    <= Cpu_d;
      Resync_q <= Resync_d;
    end
  end

  assign S                       = S_q;
  assign Ready                   = Ready_q;
  assign CKE                     = CKE_q;
  assign {nCS, nRAS, nCAS, nRWE} = cmd_q;
  assign BA                      = BA_q;
  assign RA                      = RA_q;
  assign DQML                    = DQML_q;
  assign DQMH                    = DQMH_q;
  assign VidStrb                 = Vid_q;
  assign CpuStrb                 = Cpu_q;
  assign Resync                  = Resync_q;

endmodule

// File: tb/tb_ram2e_sdram_sched.sv
// Scoreboard bench for ram2e_sdram_sched: expectations are queued with the
// absolute cycle they apply to when stimulus is driven and compared on the
// falling edge of that cycle.
module tb_ram2e_sdram_sched;

  localparam int SEL_S = 0, SEL_RDY = 1, SEL_CKE = 2, SEL_CMD = 3, SEL_BA = 4,
                 SEL_RA = 5, SEL_RAHI = 6, SEL_DQM = 7, SEL_VID = 8,
                 SEL_CPU = 9, SEL_RSY = 10;

  logic        C14M = 1'b0;
  logic        RST  = 1'b1;
  logic        PHI1 = 1'b0;
  logic [7:0]  Ain  = '0;
  logic        nWE80 = 1'b1;
  logic        EN80 = 1'b0;
  logic [7:0]  Bank = '0;
  logic [3:0]  S;
  logic        Ready, CKE, nCS, nRAS, nCAS, nRWE, DQML, DQMH;
  logic        VidStrb, CpuStrb, Resync;
  logic [1:0]  BA;
  logic [11:0] RA;

  ram2e_sdram_sched #(.INIT_WAIT(16'd16), .REF_PERIOD(8)) dut (
    .C14M(C14M), .RST(RST), .PHI1(PHI1), .Ain(Ain), .nWE80(nWE80),
    .EN80(EN80), .Bank(Bank), .S(S), .Ready(Ready), .CKE(CKE), .nCS(nCS),
    .nRAS(nRAS), .nCAS(nCAS), .nRWE(nRWE), .BA(BA), .RA(RA), .DQML(DQML),
    .DQMH(DQMH), .VidStrb(VidStrb), .CpuStrb(CpuStrb), .Resync(Resync)
  );

  always #5 C14M = ~C14M;

  typedef struct { int cyc; int sel; logic [11:0] val; } exp_t;
  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   wcount = 0;
  int   prev_len = 0;

  always @(posedge C14M) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs(input int sel);
    case (sel)
      SEL_S:    return {8'h0, S};
      SEL_RDY:  return {11'h0, Ready};
      SEL_CKE:  return {11'h0, CKE};
      SEL_CMD:  return {8'h0, nCS, nRAS, nCAS, nRWE};
      SEL_BA:   return {10'h0, BA};
      SEL_RA:   return RA;
      SEL_RAHI: return {8'h0, RA[11:8]};
      SEL_DQM:  return {10'h0, DQML, DQMH};
      SEL_VID:  return {11'h0, VidStrb};
      SEL_CPU:  return {11'h0, CpuStrb};
      default:  return {11'h0, Resync};
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_S:    return "S";
      SEL_RDY:  return "Ready";
      SEL_CKE:  return "CKE";
      SEL_CMD:  return "cmd";
      SEL_BA:   return "BA";
      SEL_RA:   return "RA";
      SEL_RAHI: return "RA_hi";
      SEL_DQM:  return "DQM";
      SEL_VID:  return "VidStrb";
      SEL_CPU:  return "CpuStrb";
      default:  return "Resync";
    endcase
  endfunction

  task automatic expect_at(input int c, input int sel, input logic [11:0] v);
    sb.push_back('{c, sel, v});
  endtask

  // Compare every expectation due in this cycle
  always @(negedge C14M) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc)
        check($sformatf("missed_%s@%0d", sel_name(e.sel), e.cyc), 12'd1, 12'd0);
      else
        check($sformatf("%s@%0d", sel_name(e.sel), e.cyc), obs(e.sel), e.val);
    end
  end

  // Init sequence with INIT_WAIT=16: FC equals cycles since reset release
  task automatic push_init(input int b);
    for (int n = 14; n <= 114; n++) begin
      int off;
      off = n - 16;
      if (n == 15 || n == 16) expect_at(b + n, SEL_CKE, 12'(n >= 16));
      if (n == 31 || n == 33 || n == 49 || n == 63 || n == 79 || n == 95 || n == 113)
        expect_at(b + n, SEL_CMD, 12'hF);
      if (off == 16) begin
        expect_at(b + n, SEL_CMD, 12'h2);
        expect_at(b + n, SEL_RA, 12'h400);
      end
      if (((off >= 32 && off <= 46) || (off >= 64 && off <= 78)) && (off % 2 == 0))
        expect_at(b + n, SEL_CMD, 12'h1);
      if (off == 56) begin
        expect_at(b + n, SEL_CMD, 12'h0);
        expect_at(b + n, SEL_BA, 12'h0);
        expect_at(b + n, SEL_RA, 12'h220);
        expect_at(b + n, SEL_DQM, 12'h3);
      end
      if (n == 42) expect_at(b + n, SEL_S, 12'h0);
      if (n == 111) expect_at(b + n, SEL_RDY, 12'h0);
      if (n == 112 || n == 114) expect_at(b + n, SEL_RDY, 12'h1);
    end
  endtask

  // Release reset and run INIT, with a PHI1 pulse that must be ignored
  task automatic init_phase();
    int b;
    RST = 1'b0;
    b = cyc;
    push_init(b);
    for (int n = 0; n < 116; n++) begin
      if (n == 40) PHI1 = 1'b1;
      if (n == 45) PHI1 = 1'b0;
      @(negedge C14M);
    end
  endtask

  task automatic push_window(input int s0, input int npush, input logic en,
                             input logic nwe, input logic [7:0] bk,
                             input logic [7:0] a, input logic rs, input logic rf);
    for (int i = 1; i <= npush; i++) begin
      int c;
      c = s0 + i - 1;
      expect_at(c, SEL_S, 12'((i > 15) ? 15 : i));
      case (i)
        1: begin
          expect_at(c, SEL_RSY, 12'(rs));
          expect_at(c, SEL_CMD, 12'hF);
          expect_at(c, SEL_CKE, 12'h1);
        end
        2: begin
          expect_at(c, SEL_CMD, 12'h3);
          expect_at(c, SEL_BA, 12'h0);
          expect_at(c, SEL_RAHI, 12'h0);
        end
        3: begin
          expect_at(c, SEL_CMD, 12'h5);
          expect_at(c, SEL_RA, {4'h4, a});
          expect_at(c, SEL_DQM, 12'h1);
        end
        4: begin
          expect_at(c, SEL_CMD, 12'hF);
          expect_at(c, SEL_DQM, 12'h3);
          expect_at(c, SEL_RSY, 12'h0);
        end
        5, 7: expect_at(c, SEL_VID, 12'h0);
        6: begin
          expect_at(c, SEL_VID, 12'h1);
          expect_at(c, SEL_CMD, rf ? 12'h1 : 12'hF);
        end
        8: begin
          expect_at(c, SEL_CMD, en ? 12'h3 : 12'hF);
          if (en) begin
            expect_at(c, SEL_BA, 12'(bk[5:4]));
            expect_at(c, SEL_RAHI, 12'(bk[3:0]));
          end
        end
        9: begin
          expect_at(c, SEL_CMD, en ? 12'({3'b010, nwe}) : 12'hF);
          if (en) begin
            expect_at(c, SEL_BA, 12'(bk[5:4]));
            expect_at(c, SEL_RA, {2'b01, 1'b0, bk[7], a});
            expect_at(c, SEL_DQM, 12'({bk[6], ~bk[6]}));
          end else begin
            expect_at(c, SEL_DQM, 12'h3);
          end
        end
        10: expect_at(c, SEL_CKE, 12'h1);
        11: begin
          expect_at(c, SEL_CKE, 12'h0);
          expect_at(c, SEL_CMD, 12'hF);
        end
        12: expect_at(c, SEL_CPU, 12'(en & nwe));
        13: expect_at(c, SEL_CPU, 12'h0);
        16: expect_at(c, SEL_CKE, 12'h0);
        default: ;
      endcase
    end
  endtask

  // One PHI1 window of len cycles; PHI1 rises at the start of the window
  task automatic window(input int len, input logic en, input logic nwe,
                        input logic [7:0] bk, input logic [7:0] a);
    logic rs, rf;
    EN80  = en;
    nWE80 = nwe;
    Bank  = bk;
    Ain   = a;
    wcount++;
    rf = (wcount % 8 == 0);
    rs = (prev_len > 0 && prev_len <= 13);
    prev_len = len;
    push_window(cyc + 1, len, en, nwe, bk, a, rs, rf);
    PHI1 = 1'b1;
    repeat (len / 2) @(negedge C14M);
    PHI1 = 1'b0;
    repeat (len - len / 2) @(negedge C14M);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge C14M);
    check("rst_S", obs(SEL_S), 12'h0);
    check("rst_Ready", obs(SEL_RDY), 12'h0);
    check("rst_CKE", obs(SEL_CKE), 12'h0);
    check("rst_cmd", obs(SEL_CMD), 12'hF);
    check("rst_BA", obs(SEL_BA), 12'h0);
    check("rst_RA", obs(SEL_RA), 12'h0);
    check("rst_DQM", obs(SEL_DQM), 12'h3);
    check("rst_strb", {9'h0, VidStrb, CpuStrb, Resync}, 12'h0);

    init_phase();

    window(14, 1'b0, 1'b1, 8'h00, 8'h12);
    window(14, 1'b1, 1'b0, 8'hC5, 8'h3C);
    window(14, 1'b1, 1'b1, 8'h3A, 8'h81);
    window(5,  1'b1, 1'b1, 8'h3A, 8'h81);
    window(14, 1'b0, 1'b1, 8'h77, 8'h44);
    window(17, 1'b1, 1'b1, 8'h96, 8'hE7);
    for (int w = 0; w < 11; w++) begin
      logic en, nwe;
      logic [7:0] bk, a;
      en  = 1'($urandom_range(0, 1));
      nwe = 1'($urandom_range(0, 1));
      bk  = 8'($urandom);
      a   = 8'($urandom);
      window(14, en, nwe, bk, a);
    end

    // Mid-run reset on the S=9 cycle of a CPU read window
    EN80 = 1'b1; nWE80 = 1'b1; Bank = 8'h5A; Ain = 8'h11;
    wcount++;
    push_window(cyc + 1, 9, 1'b1, 1'b1, 8'h5A, 8'h11, 1'b0, (wcount % 8 == 0));
    PHI1 = 1'b1;
    repeat (4) @(negedge C14M);
    PHI1 = 1'b0;
    repeat (5) @(negedge C14M);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_S", obs(SEL_S), 12'h0);
    check("mid_rst_Ready", obs(SEL_RDY), 12'h0);
    check("mid_rst_CKE", obs(SEL_CKE), 12'h0);
    check("mid_rst_cmd", obs(SEL_CMD), 12'hF);
    wcount = 0;
    prev_len = 0;
    repeat (3) @(negedge C14M);
    init_phase();
    window(14, 1'b1, 1'b1, 8'h21, 8'h5D);
    window(14, 1'b1, 1'b0, 8'h4F, 8'hA0);

    repeat (2) @(negedge C14M);
    check("sb_empty", 12'(sb.size()), 12'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
